// File: rtl/ddram_post_wr_buf_if.sv
// Bus bundle between one requestor (u_*) and one DDR3 arbiter port (d_*).
// slave is the buffer's view; master is the requestor/arbiter environment view.
interface ddram_post_wr_buf_if;
    logic [28:0] u_rd_addr;
    logic [7:0]  u_rd_burstcnt;
    logic        u_rd_req;
    logic        u_rd_ack;
    logic [63:0] u_rd_data;
    logic        u_rd_data_valid;
    logic [28:0] u_wr_addr;
    logic [63:0] u_wr_data;
    logic [7:0]  u_wr_be;
    logic        u_wr_req;
    logic        u_wr_ack;
    logic        u_wr_busy;
    logic [28:0] d_rd_addr;
    logic [7:0]  d_rd_burstcnt;
    logic        d_rd_req;
    logic        d_rd_ack;
    logic [63:0] d_rd_data;
    logic        d_rd_data_valid;
    logic [28:0] d_wr_addr;
    logic [7:0]  d_wr_burstcnt;
    logic [63:0] d_wr_data;
    logic [7:0]  d_wr_be;
    logic        d_wr_req;
    logic        d_wr_ack;
    logic        d_wr_busy;

    modport slave (
        input  u_rd_addr, u_rd_burstcnt, u_rd_req,
        input  u_wr_addr, u_wr_data, u_wr_be, u_wr_req,
        input  d_rd_ack, d_rd_data, d_rd_data_valid, d_wr_ack, d_wr_busy,
        output u_rd_ack, u_rd_data, u_rd_data_valid, u_wr_ack, u_wr_busy,
        output d_rd_addr, d_rd_burstcnt, d_rd_req,
        output d_wr_addr, d_wr_burstcnt, d_wr_data, d_wr_be, d_wr_req
    );

    modport master (
        output u_rd_addr, u_rd_burstcnt, u_rd_req,
        output u_wr_addr, u_wr_data, u_wr_be, u_wr_req,
        output d_rd_ack, d_rd_data, d_rd_data_valid, d_wr_ack, d_wr_busy,
        input  u_rd_ack, u_rd_data, u_rd_data_valid, u_wr_ack, u_wr_busy,
        input  d_rd_addr, d_rd_burstcnt, d_rd_req,
        input  d_wr_addr, d_wr_burstcnt, d_wr_data, d_wr_be, d_wr_req
    );
endinterface

// File: rtl/ddram_post_wr_buf.sv
// Posted-write FIFO and request sequencer in front of one DDR3 arbiter port.
// Define DDRAM_WR_MERGE_EN to merge a same-address write into the FIFO tail entry.
module ddram_post_wr_buf #(
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    ddram_post_wr_buf_if.slave   bus,
    output logic                 idle
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WR     = 2'd1;
    localparam logic [1:0] S_RDREQ  = 2'd2;
    localparam logic [1:0] S_RDDATA = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [7:0]            remain_q, remain_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [28:0]           addr_mem_q [DEPTH];
    logic [63:0]           data_mem_q [DEPTH];
    logic [7:0]            be_mem_q   [DEPTH];

    logic       empty, full, pop, accept, push, merge;
    logic [7:0] rd_bc_eff;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_FULL);
    assign pop       = (state_q == S_WR) && bus.d_wr_ack;
    assign rd_bc_eff = (bus.u_rd_burstcnt == 8'd0) ? 8'd1 : bus.u_rd_burstcnt;

`ifdef DDRAM_WR_MERGE_EN
    logic [DEPTH_LOG2-1:0] tail_ptr;
    logic [63:0]           be_mask;
    logic [63:0]           merged_data;
    localparam logic [DEPTH_LOG2:0] CNT_ONE = (DEPTH_LOG2+1)'(1);

    assign tail_ptr = wr_ptr_q - DEPTH_LOG2'(1);
    // The head being presented downstream must stay stable, so never merge into it.
    assign merge = !empty && (addr_mem_q[tail_ptr] == bus.u_wr_addr)
                   && !((state_q == S_WR) && (count_q == CNT_ONE));
    assign be_mask = {{8{bus.u_wr_be[7]}}, {8{bus.u_wr_be[6]}}, {8{bus.u_wr_be[5]}},
                      {8{bus.u_wr_be[4]}}, {8{bus.u_wr_be[3]}}, {8{bus.u_wr_be[2]}},
                      {8{bus.u_wr_be[1]}}, {8{bus.u_wr_be[0]}}};
    assign merged_data = (data_mem_q[tail_ptr] & ~be_mask) | (bus.u_wr_data & be_mask);
`else
    assign merge = 1'b0;
`endif

    // A same-cycle pop frees a slot, so a full FIFO can still accept.
    assign bus.u_wr_busy = (full && !pop && !merge) || bus.u_rd_req;
    assign accept        = bus.u_wr_req && !bus.u_wr_busy && !reset;
    assign push          = accept && !merge;
    assign bus.u_wr_ack  = accept;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        case (state_q)
            S_IDLE: begin
                if (!empty && !bus.d_wr_busy) begin
                    state_d = S_WR;
                end else if (empty && bus.u_rd_req) begin
                    state_d = S_RDREQ;
                end
            end
            S_WR: begin
                if (bus.d_wr_ack) state_d = S_IDLE;
            end
            S_RDREQ: begin
                if (bus.d_rd_ack) begin
                    remain_d = bus.d_rd_data_valid ? (rd_bc_eff - 8'd1) : rd_bc_eff;
                    state_d  = (remain_d == 8'd0) ? S_IDLE : S_RDDATA;
                end
            end
            S_RDDATA: begin
                if (bus.d_rd_data_valid) begin
                    remain_d = remain_q - 8'd1;
                    if (remain_q == 8'd1) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            remain_q <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            count_q  <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_q[wr_ptr_q] <= bus.u_wr_addr;
            data_mem_q[wr_ptr_q] <= bus.u_wr_data;
            be_mem_q[wr_ptr_q]   <= bus.u_wr_be;
        end
`ifdef DDRAM_WR_MERGE_EN
        else if (accept) begin
            data_mem_q[tail_ptr] <= merged_data;
            be_mem_q[tail_ptr]   <= be_mem_q[tail_ptr] | bus.u_wr_be;
        end
`endif
    end

    assign bus.d_wr_req      = (state_q == S_WR);
    assign bus.d_wr_addr     = bus.d_wr_req ? addr_mem_q[rd_ptr_q] : '0;
    assign bus.d_wr_data     = bus.d_wr_req ? data_mem_q[rd_ptr_q] : '0;
    assign bus.d_wr_be       = bus.d_wr_req ? be_mem_q[rd_ptr_q]   : '0;
    assign bus.d_wr_burstcnt = bus.d_wr_req ? 8'd1 : '0;

    assign bus.d_rd_req      = (state_q == S_RDREQ);
    assign bus.d_rd_addr     = bus.d_rd_req ? bus.u_rd_addr : '0;
    assign bus.d_rd_burstcnt = bus.d_rd_req ? rd_bc_eff : '0;

    assign bus.u_rd_ack        = bus.d_rd_ack && (state_q == S_RDREQ);
    assign bus.u_rd_data       = bus.d_rd_data;
    assign bus.u_rd_data_valid = bus.d_rd_data_valid &&
                                 ((state_q == S_RDDATA) || ((state_q == S_RDREQ) && bus.d_rd_ack));

    assign idle = empty && (state_q == S_IDLE);
endmodule
